// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
// Holds the FSM state encoding, the core data width and the ctrl stall bit positions.
package mem_bus_arbiter_pkg;

  localparam int RegBus   = 32;
  localparam int StallIf  = 1;
  localparam int StallMem = 4;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbIbus = 2'd1,
    ArbDbus = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_resp_buf.sv
// Response buffer: holds one bus read result until the owning pipeline stage advances.
// A capture always wins over consume; flush drops the valid flag but still lets data land.
module mem_bus_arbiter_resp_buf
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DW = RegBus
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_capture,
  input  logic [DW-1:0] i_data,
  input  logic          i_consume,
  input  logic          i_flush,
  output logic [DW-1:0] o_data,
  output logic          o_valid
);

  logic [DW-1:0] r_data;
  logic          r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_capture) r_data <= i_data;

      if (i_flush)                    r_valid <= 1'b0;
      else if (i_capture)             r_valid <= 1'b1;
      else if (r_valid && i_consume)  r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external memory port between instruction fetch and data access.
// Data wins ties; each transaction runs req/ack to completion and is never aborted.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DW = RegBus,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    stall_i,
  input  logic          flush_i,
  input  logic          rom_ce_i,
  input  logic [AW-1:0] rom_addr_i,
  output logic [DW-1:0] rom_data_o,
  input  logic          ram_ce_i,
  input  logic          ram_we_i,
  input  logic [3:0]    ram_sel_i,
  input  logic [AW-1:0] ram_addr_i,
  input  logic [DW-1:0] ram_data_i,
  output logic [DW-1:0] ram_data_o,
  output logic          stallreq_if_o,
  output logic          stallreq_mem_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [3:0]    bus_sel_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic [DW-1:0] bus_rdata_i,
  input  logic          bus_ack_i
);

  arb_state_e    r_state;
  logic          r_discard;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [3:0]    r_bus_sel;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;

  logic w_ivalid;
  logic w_dvalid;
  logic w_icapture;
  logic w_dcapture;
  logic w_unused_stall;

  // A fetch flushed mid-flight (or flushed on its ack edge) must not land in ibuf.
  assign w_icapture = (r_state == ArbIbus) && bus_ack_i && !r_discard && !flush_i;
  assign w_dcapture = (r_state == ArbDbus) && bus_ack_i;

  assign w_unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ArbIdle;
      r_discard   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      unique case (r_state)
        ArbIdle: begin
          if (ram_ce_i && !w_dvalid) begin
            r_state     <= ArbDbus;
            r_bus_req   <= 1'b1;
            r_bus_we    <= ram_we_i;
            r_bus_sel   <= ram_sel_i;
            r_bus_addr  <= ram_addr_i;
            r_bus_wdata <= ram_data_i;
          end else if (rom_ce_i && !w_ivalid && !flush_i) begin
            // The fetch address is stale on a flush edge, so wait for the redirect.
            r_state     <= ArbIbus;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'hF;
            r_bus_addr  <= rom_addr_i;
            r_bus_wdata <= '0;
          end
        end
        ArbIbus: begin
          if (bus_ack_i) begin
            r_state   <= ArbIdle;
            r_bus_req <= 1'b0;
            r_discard <= 1'b0;
          end else if (flush_i) begin
            r_discard <= 1'b1;
          end
        end
        ArbDbus: begin
          if (bus_ack_i) begin
            r_state   <= ArbIdle;
            r_bus_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= ArbIdle;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  mem_bus_arbiter_resp_buf #(.DW(DW)) u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_icapture),
    .i_data    (bus_rdata_i),
    .i_consume (!stall_i[StallIf]),
    .i_flush   (flush_i),
    .o_data    (rom_data_o),
    .o_valid   (w_ivalid)
  );

  mem_bus_arbiter_resp_buf #(.DW(DW)) u_dbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_dcapture),
    .i_data    (bus_rdata_i),
    .i_consume (!stall_i[StallMem]),
    .i_flush   (flush_i),
    .o_data    (ram_data_o),
    .o_valid   (w_dvalid)
  );

  assign stallreq_if_o  = rom_ce_i & ~w_ivalid;
  assign stallreq_mem_o = ram_ce_i & ~w_dvalid;

  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_sel_o   = r_bus_sel;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, collision, store, flush, held result, async reset.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter #(.DW(32), .AW(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .rom_ce_i       (rom_ce_i),
    .rom_addr_i     (rom_addr_i),
    .rom_data_o     (rom_data_o),
    .ram_ce_i       (ram_ce_i),
    .ram_we_i       (ram_we_i),
    .ram_sel_i      (ram_sel_i),
    .ram_addr_i     (ram_addr_i),
    .ram_data_i     (ram_data_i),
    .ram_data_o     (ram_data_o),
    .stallreq_if_o  (stallreq_if_o),
    .stallreq_mem_o (stallreq_mem_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_sel_o      (bus_sel_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall_i = '0; flush_i = 1'b0;
    rom_ce_i = 1'b0; rom_addr_i = '0;
    ram_ce_i = 1'b0; ram_we_i = 1'b0; ram_sel_i = '0; ram_addr_i = '0; ram_data_i = '0;
    bus_rdata_i = '0; bus_ack_i = 1'b0;
    #1;
    check("rst_req",   {31'd0, bus_req_o},   32'd0);
    check("rst_addr",  bus_addr_o,           32'd0);
    check("rst_ibuf",  rom_data_o,           32'd0);
    check("rst_dbuf",  ram_data_o,           32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---- Fetch only: ack sampled on the 2nd edge after issue
    rom_ce_i = 1'b1; rom_addr_i = 32'h0000_0010; stall_i = 6'b000010;
    #1 check("f_stall_c1", {31'd0, stallreq_if_o}, 32'd1);
    tick();
    check("f_req",     {31'd0, bus_req_o}, 32'd1);
    check("f_addr",    bus_addr_o, 32'h0000_0010);
    check("f_sel",     {28'd0, bus_sel_o}, 32'hF);
    check("f_we",      {31'd0, bus_we_o}, 32'd0);
    check("f_stall_c2", {31'd0, stallreq_if_o}, 32'd1);
    tick();
    check("f_stall_c3", {31'd0, stallreq_if_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h3401_1100;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    check("f_stall_low", {31'd0, stallreq_if_o}, 32'd0);
    check("f_data",      rom_data_o, 32'h3401_1100);
    check("f_req_low",   {31'd0, bus_req_o}, 32'd0);
    tick();
    check("f_held_stall", {31'd0, stallreq_if_o}, 32'd0);
    stall_i = 6'b000000;
    tick();
    check("f_consumed", {31'd0, stallreq_if_o}, 32'd1);
    check("f_no_reissue", {31'd0, bus_req_o}, 32'd0);
    check("f_data_keep", rom_data_o, 32'h3401_1100);
    rom_ce_i = 1'b0;
    tick();

    // ---- Collision: data goes first, fetch after one idle cycle
    rom_ce_i = 1'b1; rom_addr_i = 32'h0000_0020;
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 4'hF; ram_addr_i = 32'h0000_0100;
    tick();
    check("c_addr_data", bus_addr_o, 32'h0000_0100);
    check("c_we",        {31'd0, bus_we_o}, 32'd0);
    check("c_smem_hi",   {31'd0, stallreq_mem_o}, 32'd1);
    check("c_sif_hi",    {31'd0, stallreq_if_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_0001;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    check("c_smem_low",  {31'd0, stallreq_mem_o}, 32'd0);
    check("c_sif_still", {31'd0, stallreq_if_o}, 32'd1);
    check("c_dbuf",      ram_data_o, 32'hCAFE_0001);
    check("c_idle_gap",  {31'd0, bus_req_o}, 32'd0);
    ram_ce_i = 1'b0;
    tick();
    check("c_fetch_req",  {31'd0, bus_req_o}, 32'd1);
    check("c_fetch_addr", bus_addr_o, 32'h0000_0020);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    check("c_sif_low", {31'd0, stallreq_if_o}, 32'd0);
    check("c_ibuf",    rom_data_o, 32'h1111_2222);
    rom_ce_i = 1'b0;
    tick();

    // ---- Store with immediate ack
    ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_sel_i = 4'b0011;
    ram_addr_i = 32'h0000_0200; ram_data_i = 32'hDEAD_BEEF;
    #1 check("s_smem_hi", {31'd0, stallreq_mem_o}, 32'd1);
    tick();
    check("s_req",   {31'd0, bus_req_o}, 32'd1);
    check("s_we",    {31'd0, bus_we_o}, 32'd1);
    check("s_sel",   {28'd0, bus_sel_o}, 32'h3);
    check("s_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    check("s_addr",  bus_addr_o, 32'h0000_0200);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    check("s_smem_low", {31'd0, stallreq_mem_o}, 32'd0);
    check("s_req_low",  {31'd0, bus_req_o}, 32'd0);
    ram_ce_i = 1'b0; ram_we_i = 1'b0; ram_data_i = '0;
    tick();

    // ---- Flush while a fetch is outstanding
    rom_ce_i = 1'b1; rom_addr_i = 32'h0000_0030;
    tick();
    check("x_addr", bus_addr_o, 32'h0000_0030);
    flush_i = 1'b1; rom_addr_i = 32'h0000_0040;
    tick();
    flush_i = 1'b0;
    check("x_req_kept",  {31'd0, bus_req_o}, 32'd1);
    check("x_addr_held", bus_addr_o, 32'h0000_0030);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    check("x_ibuf_kept", rom_data_o, 32'h1111_2222);
    check("x_not_valid", {31'd0, stallreq_if_o}, 32'd1);
    check("x_idle",      {31'd0, bus_req_o}, 32'd0);
    tick();
    check("x_refetch_req",  {31'd0, bus_req_o}, 32'd1);
    check("x_refetch_addr", bus_addr_o, 32'h0000_0040);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h2402_0005;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    check("x_refetch_data", rom_data_o, 32'h2402_0005);
    rom_ce_i = 1'b0;
    tick();

    // ---- Load result held while MEM/WB is stalled
    stall_i = 6'b010000;
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 4'hF; ram_addr_i = 32'h0000_0300;
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h5A5A_0300;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    check("h_dbuf", ram_data_o, 32'h5A5A_0300);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("h_no_req",    {31'd0, bus_req_o}, 32'd0);
      check("h_dbuf_held", ram_data_o, 32'h5A5A_0300);
      check("h_smem_low",  {31'd0, stallreq_mem_o}, 32'd0);
    end
    stall_i = 6'b000000;
    tick();
    check("h_consumed", {31'd0, stallreq_mem_o}, 32'd1);
    check("h_no_req2",  {31'd0, bus_req_o}, 32'd0);
    ram_ce_i = 1'b0;
    tick();

    // ---- Asynchronous reset in the middle of a data transaction
    ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_sel_i = 4'hF;
    ram_addr_i = 32'h0000_0400; ram_data_i = 32'h1234_5678;
    tick();
    check("r_req_before", {31'd0, bus_req_o}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("r_req",   {31'd0, bus_req_o}, 32'd0);
    check("r_we",    {31'd0, bus_we_o}, 32'd0);
    check("r_sel",   {28'd0, bus_sel_o}, 32'd0);
    check("r_addr",  bus_addr_o, 32'd0);
    check("r_wdata", bus_wdata_o, 32'd0);
    check("r_ibuf",  rom_data_o, 32'd0);
    check("r_dbuf",  ram_data_o, 32'd0);
    ram_ce_i = 1'b0; ram_we_i = 1'b0; ram_data_i = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("r_idle_after", {31'd0, bus_req_o}, 32'd0);
    ram_ce_i = 1'b1; ram_sel_i = 4'hF; ram_addr_i = 32'h0000_0500;
    tick();
    check("r_new_req",  {31'd0, bus_req_o}, 32'd1);
    check("r_new_addr", bus_addr_o, 32'h0000_0500);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    check("r_new_data", ram_data_o, 32'h0BAD_F00D);
    ram_ce_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external synchronous memory port between instruction fetch (rom_* side of the core) and data access (ram_* side of the core).
- Serialises the two requesters with a req/ack handshake that tolerates wait states.
- Buffers each response until the owning pipeline stage consumes it.
- Raises stall requests toward ctrl while a requester is still waiting.
- Sits between the openmips core and the top-level memory/peripheral bus.

Parameters:
- DW, 32, data bus width
- AW, 32, address bus width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- stall_i  in  6  pipeline stall vector from ctrl (bit1 = IF/ID hold, bit4 = MEM/WB hold)
- flush_i  in  1  exception flush from ctrl
- rom_ce_i  in  1  fetch request from pc_reg
- rom_addr_i  in  AW  fetch address
- rom_data_o  out  DW  fetched instruction (ibuf)
- ram_ce_i  in  1  data access request from mem stage (OR of ram_ce_o[3:0])
- ram_we_i  in  1  data write enable
- ram_sel_i  in  4  byte lane select
- ram_addr_i  in  AW  data address
- ram_data_i  in  DW  store data
- ram_data_o  out  DW  load data (dbuf)
- stallreq_if_o  out  1  fetch not yet satisfied
- stallreq_mem_o  out  1  data access not yet satisfied
- bus_req_o  out  1  external request
- bus_we_o  out  1  external write enable
- bus_sel_o  out  4  external byte select
- bus_addr_o  out  AW  external address
- bus_wdata_o  out  DW  external write data
- bus_rdata_i  in  DW  external read data
- bus_ack_i  in  1  external acknowledge (1 cycle, ≥1 cycle after req)

Behaviour:
- Reset (rst_n=0, async): state=IDLE; ibuf=0, dbuf=0, ivalid=0, dvalid=0, discard=0; all outputs 0.
- Stall outputs are combinational:
  - stallreq_if_o = rom_ce_i & ~ivalid
  - stallreq_mem_o = ram_ce_i & ~dvalid
- rom_data_o=ibuf, ram_data_o=dbuf.
- FSM states: IDLE, IBUS, DBUS.
  - IDLE: if ram_ce_i & ~dvalid, go to DBUS and latch ram_* into the bus_* registers. Else if rom_ce_i & ~ivalid, go to IBUS and latch rom_addr_i, with we=0 and sel=4'hF. Data has priority because it is the older instruction.
  - IBUS/DBUS: bus_req_o=1. bus_addr/we/sel/wdata are held stable until ack. On bus_ack_i return to IDLE; a new request can issue the cycle after ack (min 1 idle cycle between transactions).
- Response capture:
  - Ack in IBUS: if discard=0, ibuf<=bus_rdata_i and ivalid<=1. discard<=0 in either case.
  - Ack in DBUS: dbuf<=bus_rdata_i (don't-care for writes) and dvalid<=1.
- Consume:
  - ivalid cleared on any clock edge where ivalid=1 and stall_i[1]=0 (IF/ID advances).
  - dvalid cleared where dvalid=1 and stall_i[4]=0.
  - Capture and clear in the same cycle cannot collide: a stalled requester cannot advance until its valid is set.
- Latency: read data visible 1 cycle after ack; stallreq drops in that same cycle.
- Flush:
  - flush_i=1 clears ivalid and dvalid.
  - If the state is IBUS, sets discard=1. The external transaction is never aborted; it completes and its data is dropped.
  - A DBUS transaction in progress completes normally. mem gates ce for excepting instructions, so the store in flight belongs to a committed instruction.
  - flush_i coincident with ack in IBUS: data dropped, ivalid stays 0.
- Simultaneous first requests in IDLE: DBUS first, IBUS next.
- While a requester is stalled the held rom/ram inputs are stable. The arbiter does not re-sample them after issue.
- Requester deasserts ce mid-transaction (only possible after flush): the transaction still completes, and the result is discarded (fetch) or buffered then cleared by flush (data).
- No timeout; a bus that never acks hangs the core by design.

Decomposition:
- Shared package/macro file: state encodings (ArbIdle, ArbIbus, ArbDbus), `RegBus width, stall bit indices StallIf=1 and StallMem=4.
- No sub-module is needed. Optionally factor a resp_buf (data reg + valid + consume/flush clear) instantiated twice.

Test Plan:
- Fetch only: rom_ce=1, addr=0x0000_0010, ack after 2 cycles with rdata=0x3401_1100. Required: stallreq_if high for 3 cycles, then rom_data_o=0x3401_1100, ivalid cleared on the first edge with stall_i[1]=0.
- Collision: rom_ce and ram_ce (load, addr 0x100) rise in the same cycle. Required: bus_addr_o=0x100 first. The fetch issues after the data ack + 1 idle cycle, and stallreq_mem drops before stallreq_if.
- Store: ram_we=1, sel=4'b0011, wdata=0xDEAD_BEEF, ack immediate next cycle. Required: bus_we_o/sel/wdata stable until ack, and stallreq_mem_o low 1 cycle after ack.
- Flush during IBUS: flush_i pulses while waiting; ack later returns 0xFFFF_FFFF. Required: ivalid stays 0, rom_data_o unchanged, and a fresh fetch issues after returning to IDLE.
- Held result: a load completes while stall_i[4]=1 for 3 cycles. Required: ram_data_o holds dbuf and no second bus request issues for that load.
- Async reset mid-DBUS: rst_n low between clock edges. Required: bus_req_o and all outputs go to 0 immediately, without waiting for a clock edge; the FSM is in IDLE after release.
